// File: rtl/multdiv_seq.sv
// multdiv_seq: multi-cycle signed multiply / divide execution unit.
//
// Sits after the instruction decoder. When it accepts an op it runs WIDTH
// shift-add (MULT) or restoring-divide (DIV) iterations on the operand
// magnitudes. It holds the pipeline with stall while it works, then issues
// one writeback packet.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   ctrl_MULT, ctrl_DIV   decoder strobes (MULT wins if both are high)
//   operandA, operandB    rs / rt values (multiplicand,dividend / multiplier,divisor)
//   dest_rd               destination register of the issuing instruction
//   stall                 combinational hold for fetch/decode
//   result_valid          one-cycle writeback strobe
//   result, result_rd     writeback value and register (rd, or RSTATUS_REG on fault)
//   exception             qualifies a faulting packet (mult overflow / divide by zero)
//
// Optional build macro MULTDIV_EARLY_ZERO_EN: ops with a zero operand skip
// the iterations and complete in the cycle after accept.

module multdiv_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned MULT_EXC    = 4,
  parameter int unsigned DIV_EXC     = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       dest_rd,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd,
  output logic             exception
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic                 is_mult_q, is_mult_d;
  logic                 neg_q, neg_d;
  logic                 div0_q, div0_d;
  logic [4:0]           rd_q, rd_d;
  logic                 result_valid_q, result_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [4:0]           result_rd_q, result_rd_d;
  logic                 exception_q, exception_d;

  logic                 start;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_part, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, acc_iter, prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic                 mul_ovf;

  always_comb begin
    start = ctrl_MULT | ctrl_DIV;
    stall = (state_q == S_BUSY) | (start & (state_q != S_BUSY));

    abs_a = operandA[WIDTH-1] ? -operandA : operandA;
    abs_b = operandB[WIDTH-1] ? -operandB : operandB;

    // MULT: acc = {partial sum, remaining multiplier bits}; add then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // DIV: acc = {remainder, dividend/quotient}; shift left, trial-subtract.
    // The remainder stays below the divisor (<= 2^(WIDTH-1)), so its
    // shifted form fits in WIDTH+1 bits and the borrow lands in bit WIDTH.
    div_part  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_part - {1'b0, mag_q};
    if (!div_trial[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    acc_iter = is_mult_q ? mul_next : div_next;
    prod_s   = neg_q ? -acc_iter : acc_iter;
    quo_s    = neg_q ? -acc_iter[WIDTH-1:0] : acc_iter[WIDTH-1:0];
    mul_ovf  = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));

    state_d        = state_q;
    counter_d      = counter_q;
    acc_d          = acc_q;
    mag_d          = mag_q;
    is_mult_d      = is_mult_q;
    neg_d          = neg_q;
    div0_d         = div0_q;
    rd_d           = rd_q;
    result_valid_d = 1'b0;
    result_d       = result_q;
    result_rd_d    = result_rd_q;
    exception_d    = exception_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_BUSY;
          counter_d = '0;
          is_mult_d = ctrl_MULT;
          neg_d     = operandA[WIDTH-1] ^ operandB[WIDTH-1];
          div0_d    = ~ctrl_MULT & (operandB == '0);
          rd_d      = dest_rd;
          // mag holds the addend (MULT) or divisor (DIV); the low half of
          // acc holds the bits consumed one per iteration.
          mag_d     = ctrl_MULT ? abs_a : abs_b;
          acc_d     = {{WIDTH{1'b0}}, (ctrl_MULT ? abs_b : abs_a)};
`ifdef MULTDIV_EARLY_ZERO_EN
          if ((operandA == '0) || (operandB == '0)) begin
            state_d        = S_DONE;
            result_valid_d = 1'b1;
            if (!ctrl_MULT && (operandB == '0)) begin
              result_d    = WIDTH'(DIV_EXC);
              result_rd_d = 5'(RSTATUS_REG);
              exception_d = 1'b1;
            end else begin
              result_d    = '0;
              result_rd_d = dest_rd;
              exception_d = 1'b0;
            end
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d     = acc_iter;
        counter_d = counter_q + 1'b1;
        if (counter_q == CNT_W'(WIDTH-1)) begin
          // Packet is built from the final iteration so it is registered
          // and visible during the DONE cycle.
          state_d        = S_DONE;
          counter_d      = '0;
          result_valid_d = 1'b1;
          if (is_mult_q && mul_ovf) begin
            result_d    = WIDTH'(MULT_EXC);
            result_rd_d = 5'(RSTATUS_REG);
            exception_d = 1'b1;
          end else if (!is_mult_q && div0_q) begin
            result_d    = WIDTH'(DIV_EXC);
            result_rd_d = 5'(RSTATUS_REG);
            exception_d = 1'b1;
          end else begin
            result_d    = is_mult_q ? prod_s[WIDTH-1:0] : quo_s;
            result_rd_d = rd_q;
            exception_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      counter_q      <= '0;
      acc_q          <= '0;
      mag_q          <= '0;
      is_mult_q      <= 1'b0;
      neg_q          <= 1'b0;
      div0_q         <= 1'b0;
      rd_q           <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_rd_q    <= '0;
      exception_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      acc_q          <= acc_d;
      mag_q          <= mag_d;
      is_mult_q      <= is_mult_d;
      neg_q          <= neg_d;
      div0_q         <= div0_d;
      rd_q           <= rd_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_rd_q    <= result_rd_d;
      exception_q    <= exception_d;
    end
  end

  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_rd    = result_rd_q;
  assign exception    = exception_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] operandA, operandB;
  logic [4:0]  dest_rd;
  logic        stall, result_valid, exception;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] exp_r;
  logic [4:0]  exp_rd;
  logic        exp_ex;

  multdiv_seq #(.WIDTH(32), .RSTATUS_REG(30), .MULT_EXC(4), .DIV_EXC(5)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .operandA(operandA), .operandB(operandB), .dest_rd(dest_rd), .stall(stall),
    .result_valid(result_valid), .result(result), .result_rd(result_rd),
    .exception(exception)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers.
  function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, output logic [31:0] r,
                                output logic [4:0] rrd, output logic ex);
    longint sa, sb, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; rrd = rd; ex = 1'b0;
    if (is_mult) begin
      p = sa * sb;
      if (p > 64'sd2147483647 || p < -64'sd2147483648) begin
        r = 32'd4; rrd = 5'd30; ex = 1'b1;
      end else r = p[31:0];
    end else begin
      if (b == 32'd0) begin
        r = 32'd5; rrd = 5'd30; ex = 1'b1;
      end else begin
        q = sa / sb;
        r = q[31:0];
      end
    end
  endfunction

  function automatic int unsigned latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_ZERO_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Called at a negedge with the unit IDLE or DONE; returns at the negedge
  // of the DONE cycle. inject pulses a DIV strobe mid-op, which must be ignored.
  task automatic do_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit inject, input string tag);
    int unsigned n = 0;
    bit found = 0;
    bit stall_ok = 1;
    ctrl_MULT = is_mult; ctrl_DIV = !is_mult;
    operandA = a; operandB = b; dest_rd = rd;
    model(is_mult, a, b, rd, exp_r, exp_rd, exp_ex);
    #1 check({tag, "_stall_issue"}, stall, 1);
    while (n < 100 && !found) begin
      @(negedge clock);
      n++;
      ctrl_MULT = 0; ctrl_DIV = 0;
      if (inject && n == 10) begin
        ctrl_DIV = 1; operandA = $urandom; operandB = $urandom; dest_rd = 5'd17;
      end
      #1;
      if (result_valid) found = 1;
      else if (!stall) stall_ok = 0;
    end
    check({tag, "_latency"}, n, latency(a, b));
    check({tag, "_stall_busy"}, stall_ok, 1);
    check({tag, "_stall_done"}, stall, 0);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_rd"}, result_rd, exp_rd);
    check({tag, "_exc"}, exception, exp_ex);
  endtask

  // Idle cycles: no strobe, packet held.
  task automatic idle(input int unsigned k, input string tag);
    bit spurious = 0;
    bit held = 1;
    ctrl_MULT = 0; ctrl_DIV = 0;
    for (int unsigned i = 0; i < k; i++) begin
      @(negedge clock);
      #1;
      if (result_valid) spurious = 1;
      if (result !== exp_r || result_rd !== exp_rd || exception !== exp_ex) held = 0;
    end
    check({tag, "_no_valid"}, spurious, 0);
    check({tag, "_hold"}, held, 1);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 40);
      4: v = -$urandom_range(1, 40);
      5: begin v = $urandom; v = {{16{v[15]}}, v[15:0]}; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset_n = 0; ctrl_MULT = 0; ctrl_DIV = 0;
    operandA = '0; operandB = '0; dest_rd = '0;
    #3;
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_rd", result_rd, 0);
    check("rst_exc", exception, 0);
    check("rst_stall", stall, 0);
    @(negedge clock); reset_n = 1;
    @(negedge clock);

    do_op(1, 32'hFFFF_FFF9, 32'd6, 5'd5, 0, "mul_neg");
    idle(2, "mul_neg");
    do_op(1, 32'h0001_0000, 32'h0001_0000, 5'd3, 0, "mul_ovf");
    idle(2, "mul_ovf");
    do_op(0, -32'd17, 32'd5, 5'd8, 0, "div_neg");
    idle(1, "div_neg");
    do_op(0, 32'd9, 32'd0, 5'd8, 0, "div_zero");
    idle(1, "div_zero");
    do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, "div_min");
    idle(1, "div_min");
    do_op(1, 32'h8000_0000, 32'd1, 5'd10, 0, "mul_min");
    idle(1, "mul_min");
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, "mul_minneg");
    idle(1, "mul_minneg");

    // Back-to-back: second op issued in the DONE cycle of the first.
    do_op(0, 32'd100, -32'd7, 5'd12, 0, "b2b_first");
    do_op(1, 32'd3, 32'd4, 5'd13, 0, "b2b_second");
    idle(2, "b2b");

    do_op(1, 32'd25, -32'd25, 5'd14, 1, "inject");
    idle(2, "inject");

    do_op(1, 32'd0, 32'd123, 5'd15, 0, "mul_zero");
    idle(2, "mul_zero");
    do_op(0, 32'd0, 32'd0, 5'd16, 0, "div_zz");
    idle(2, "div_zz");

    // Asynchronous reset in the middle of an op.
    ctrl_MULT = 1; operandA = 32'd7; operandB = 32'd9; dest_rd = 5'd4;
    @(negedge clock); ctrl_MULT = 0;
    repeat (5) @(negedge clock);
    #2 reset_n = 0;
    #1;
    check("midrst_valid", result_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_rd", result_rd, 0);
    check("midrst_exc", exception, 0);
    check("midrst_stall", stall, 0);
    @(negedge clock); reset_n = 1;
    exp_r = '0; exp_rd = '0; exp_ex = 0;
    idle(40, "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit m;
      a = rand_opnd(); b = rand_opnd(); m = $urandom_range(0, 1);
      do_op(m, a, b, 5'($urandom_range(0, 31)), 0, "rand");
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3), "rand");
    end
    idle(3, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
